// File: rtl/sna_resp_scheduler.sv
// sna_resp_scheduler
//   Response-path controller for the slave-side network adapter. Arbitrates
//   between the AXI4-Lite R and B channels, captures one response, claims a
//   free virtual channel and sends a two-flit packet (header, tail) into the
//   NoC.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rdata/rvalid/rready AXI read-data channel (rready combinational in IDLE)
//   bresp/bvalid/bready AXI write-response channel (bready combinational in IDLE)
//   pov_addr            destination node, sampled together with the response
//   vc_free             per-VC availability, bit i = VC i free
//   vc_claim            one-hot single-cycle pulse naming the VC taken
//   flit/flit_valid/flit_ready  NoC output; flit[33:32] = 10 header, 01 tail
//   dbg_state           current FSM state: 0 IDLE, 1 ALLOC, 2 HEAD, 3 TAIL
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The sender holds its payload stable while valid is high and
// ready is low; ready may depend combinationally on valid.
module sna_resp_scheduler #(
  parameter logic [3:0] SRC_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  input  logic [3:0]  pov_addr,
  input  logic [7:0]  vc_free,
  output logic [7:0]  vc_claim,
  output logic [33:0] flit,
  output logic        flit_valid,
  input  logic        flit_ready,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    HEAD  = 2'd2,
    TAIL  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        kind_q;          // 1 = read response, 0 = write response
  logic [31:0] payload_q;
  logic [3:0]  dest_q;
  logic [2:0]  vc_id_q;
  logic        last_grant_b_q;  // 1 when the most recent grant went to B

  logic        grant_r;
  logic        grant_b;
  logic [2:0]  free_idx;
  logic        free_any;

  // Round-robin between R and B: on a tie the channel not granted last wins.
  assign grant_r = rvalid && (!bvalid || last_grant_b_q);
  assign grant_b = bvalid && !grant_r;

  // Lowest-numbered free VC; scanning downward lets the lowest index win.
  always_comb begin
    free_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vc_free[i]) free_idx = 3'(i);
    end
  end
  assign free_any = |vc_free;

  always_comb begin
    state_nxt  = state;
    rready     = 1'b0;
    bready     = 1'b0;
    vc_claim   = 8'h00;
    flit       = 34'd0;
    flit_valid = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so the ready outputs stay low while reset is held.
        rready = rst_n && grant_r;
        bready = rst_n && grant_b;
        if (grant_r || grant_b) state_nxt = ALLOC;
      end
      ALLOC: begin
        if (free_any) begin
          vc_claim  = 8'b1 << free_idx;
          state_nxt = HEAD;
        end
      end
      HEAD: begin
        flit_valid = 1'b1;
        flit       = {2'b10, vc_id_q, dest_q, SRC_ID, 20'd0, kind_q};
        if (flit_ready) state_nxt = TAIL;
      end
      TAIL: begin
        flit_valid = 1'b1;
        flit       = {2'b01, payload_q};
        if (flit_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      kind_q         <= 1'b0;
      payload_q      <= 32'd0;
      dest_q         <= 4'd0;
      vc_id_q        <= 3'd0;
      last_grant_b_q <= 1'b1;
    end else begin
      state <= state_nxt;
      // Capture happens only on the grant, so later input changes are ignored.
      if (state == IDLE && (grant_r || grant_b)) begin
        kind_q         <= grant_r;
        payload_q      <= grant_r ? rdata : {30'd0, bresp};
        dest_q         <= pov_addr;
        last_grant_b_q <= grant_b;
      end
      if (state == ALLOC && free_any) vc_id_q <= free_idx;
    end
  end

  assign dbg_state = state;

endmodule
